// File: rtl/alu_pipe.sv
// alu_pipe: pipelined WIDTH-bit VeriRISC ALU with valid handshake, carry and zero flags.
// Optional build macro ALU_PIPE_SAT_ADD_EN: ADD saturates to all ones on overflow (carry still 1).

package typedefs_v2;
    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;
endpackage

module alu_pipe
    import typedefs_v2::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             in_valid,
    input  opcode_t          opcode,
    input  logic [WIDTH-1:0] accum,
    input  logic [WIDTH-1:0] data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry
);

    // {carry, result} for one instruction; all arithmetic is unsigned.
    function automatic logic [WIDTH:0] alu_result(
        input opcode_t          op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, d};
        case (op)
            ADD: begin
`ifdef ALU_PIPE_SAT_ADD_EN
                if (sum[WIDTH]) begin
                    alu_result = {1'b1, {WIDTH{1'b1}}};
                end else begin
                    alu_result = sum;
                end
`else
                alu_result = sum;
`endif
            end
            AND:     alu_result = {1'b0, a & d};
            XOR:     alu_result = {1'b0, a ^ d};
            LDA:     alu_result = {1'b0, d};
            HLT,
            SKZ,
            STO,
            JMP:     alu_result = {1'b0, a};
            default: alu_result = {1'b0, a};
        endcase
    endfunction

    logic             s1_valid_r;
    opcode_t          s1_op_r;
    logic [WIDTH-1:0] s1_accum_r;
    logic [WIDTH-1:0] s1_data_r;

    logic [WIDTH:0]   res_s;
    logic             zero_s;

    logic [LATENCY-1:0]            valid_r;
    logic [LATENCY-1:0][WIDTH-1:0] out_r;
    logic [LATENCY-1:0]            zero_r;
    logic [LATENCY-1:0]            carry_r;

    // Stage 1: capture operands and opcode of each accepted transaction.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= HLT;
            s1_accum_r <= {WIDTH{1'b0}};
            s1_data_r  <= {WIDTH{1'b0}};
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_op_r    <= opcode;
                s1_accum_r <= accum;
                s1_data_r  <= data;
            end
        end
    end

    // Result and zero flag evaluated from the stage-1 registers.
    always_comb begin
        res_s  = alu_result(s1_op_r, s1_accum_r, s1_data_r);
        zero_s = (s1_accum_r == {WIDTH{1'b0}});
    end

    // Result register followed by LATENCY-1 delay stages; payload only
    // loads behind a valid bit, so the last stage holds across idle cycles.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            valid_r <= {LATENCY{1'b0}};
            out_r   <= {(LATENCY*WIDTH){1'b0}};
            zero_r  <= {LATENCY{1'b0}};
            carry_r <= {LATENCY{1'b0}};
        end else begin
            valid_r[0] <= s1_valid_r;
            if (s1_valid_r) begin
                out_r[0]   <= res_s[WIDTH-1:0];
                carry_r[0] <= res_s[WIDTH];
                zero_r[0]  <= zero_s;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_r[i] <= valid_r[i-1];
                if (valid_r[i-1]) begin
                    out_r[i]   <= out_r[i-1];
                    carry_r[i] <= carry_r[i-1];
                    zero_r[i]  <= zero_r[i-1];
                end
            end
        end
    end

    assign out_valid = valid_r[LATENCY-1];
    assign out       = out_r[LATENCY-1];
    assign zero      = zero_r[LATENCY-1];
    assign carry     = carry_r[LATENCY-1];

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle 8-bit VeriRISC ALU.
- Same eight-opcode instruction set (opcode_t from typedefs_v2), generalised to WIDTH bits and a configurable result latency.
- Adds a valid handshake, a carry flag, and a zero flag registered in step with the result.
- Sits between the accumulator and the memory/data bus in the CPU datapath. Also usable as a standalone execution unit.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 2..32.
- LATENCY, 1: clock cycles from an accepted input to its result; legal range 1..4.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_  input  1  asynchronous, active-low reset
- in_valid  input  1  operands and opcode are valid this cycle
- opcode  input  opcode_t (3)  HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7
- accum  input  WIDTH  accumulator operand
- data  input  WIDTH  data/memory operand
- out_valid  output  1  out/zero/carry hold a new result this cycle
- out  output  WIDTH  result
- zero  output  1  registered (accum == 0) of the transaction being presented
- carry  output  1  carry-out of ADD; 0 for every other opcode

Behaviour:
- Clock and reset: one clock, clk. rst_ is asynchronous and active-low.
- Reset values, while rst_ is low and immediately after assertion:
  - out_valid=0, out=0, zero=0, carry=0.
  - All internal pipeline valid bits cleared.
  - Reset mid-operation discards every in-flight transaction; none emerges after release.
- Acceptance: a transaction is captured on each rising clk with in_valid=1. There is no backpressure; one transaction per cycle, back-to-back, is required.
- Latency: a transaction accepted at edge N is presented from edge N+LATENCY. out_valid is high for exactly one cycle per accepted transaction. Order is preserved.
- Result function, evaluated on the captured operands:
  - HLT, SKZ, STO, JMP: out=accum, carry=0
  - ADD: {carry,out} = accum + data, computed at WIDTH+1 bits
  - AND: out = accum & data, carry=0
  - XOR: out = accum ^ data, carry=0
  - LDA: out = data, carry=0
- zero is computed from the captured accum, not from out, and travels through the pipeline with its result.
- Idle cycles (in_valid=0):
  - Produce out_valid=0 when they reach the output stage.
  - out, zero and carry hold their last presented values; they do not update on invalid cycles.
- Pipeline structure:
  - Stage 1 registers operands, opcode and valid.
  - The result is computed combinationally from stage 1.
  - Stages 2..LATENCY are pure delay registers for {valid, out, zero, carry}.
  - For LATENCY=1, the output register is stage 1's result register.
- Width rules:
  - ADD wraps modulo 2^WIDTH; carry captures bit WIDTH.
  - No sign interpretation; all operations are unsigned.
- Simultaneous events: reset dominates in_valid.

Optional Feature:
- Macro: ALU_PIPE_SAT_ADD_EN.
- Defined: ADD saturates. When the WIDTH+1-bit sum overflows, out = all ones, and carry still reports 1. Other opcodes are unchanged.
- Undefined: ADD wraps as described in Behaviour.

Test Plan:
- Opcode sweep: WIDTH=8, LATENCY=1, data=0x37, accum=0xDA, opcodes 0..7 with in_valid=1 one per cycle. Results one cycle after each:
  - out = DA, DA, 11, 12, ED, 37, DA, DA.
  - carry=1 only for ADD.
  - zero=0 throughout.
  - Follow with ADD data=0x07, accum=0x12: out=0x19, carry=0.
- Zero flag: LDA data=0x72, accum=0x00: out=0x72, zero=1. Then AND data=0x1F, accum=0x35: out=0x15, zero=0.
- Latency and streaming: LATENCY=3, five back-to-back transactions, then a 2-cycle gap, then one more.
  - out_valid rises exactly 3 edges after each accept.
  - Results emerge in order.
  - Gap cycles show out_valid=0 and out holds the last value.
- Width generalisation: WIDTH=16, ADD accum=0xFFFF, data=0x0001: out=0x0000, carry=1, zero=0.
- Reset mid-pipeline: LATENCY=4, three transactions issued, then rst_ pulled low asynchronously mid-cycle.
  - Outputs go to 0 immediately.
  - After release, no out_valid pulse appears for the discarded transactions.
- Saturation: with ALU_PIPE_SAT_ADD_EN defined, WIDTH=8, ADD accum=0xDA, data=0x37: out=0xFF, carry=1. Without the macro: out=0x11, carry=1.
